branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer end of the ALU flag interface (Z, N, C, V) in the EX stage of the 5-stage RV32I pipeline. It takes the flags the ALU produces for a subtract-compare, evaluates the B-type/JAL/JALR condition, and registers the decision. It then sequences the one-cycle PC redirect and the pipeline flush toward fetch and hazard logic, and keeps saturating branch statistics.

Parameters:
XLEN, 32, width of PC target
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-low reset
valid_e  in  1  EX holds a real (non-bubble) instruction
stall_e  in  1  EX held by hazard unit this cycle
branch_e  in  1  EX instruction is B-type
jump_e  in  1  EX instruction is JAL/JALR
funct3_e  in  3  branch funct3
zero_e  in  1  ALU Z
neg_e  in  1  ALU N
carry_e  in  1  ALU C (carry-out of A+~B+1)
ovf_e  in  1  ALU V
pc_target_e  in  XLEN  computed branch/jump target
pcsrc_o  out  1  select redirect target in fetch
pc_target_o  out  XLEN  registered redirect target
flush_d_o  out  1  squash IF/ID register
flush_e_o  out  1  squash ID/EX register
illegal_br_o  out  1  one-cycle pulse: B-type with funct3 010/011
br_count_o  out  CNT_W  resolved branches+jumps
taken_count_o  out  CNT_W  redirects issued

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pc_target_o 0; counters 0. Deassertion is synchronous to clk at the design level; the block requires no special handling.
- Accept condition, evaluated in IDLE only: valid_e & ~stall_e & (branch_e | jump_e).
- Condition table (flags from A-B):
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010 and 011: not taken, and illegal_br_o pulses for 1 cycle.
- jump_e is always taken, and funct3 is ignored. If branch_e and jump_e are both set, jump_e wins.
- FSM with 2 states:
  - IDLE: on accept, br_count increments. If taken, latch pc_target_e into pc_target_o, increment taken_count, and go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: lasts exactly 1 cycle. pcsrc_o, flush_d_o and flush_e_o are all 1. The instruction in EX this cycle is wrong-path, so valid_e, branch_e and jump_e are ignored. stall_e is ignored, so REDIRECT is never extended. Next state is IDLE.
- Latency: the branch is in EX at cycle N. Redirect and flush are asserted at cycle N+1 and are registered outputs. No back-to-back redirects are possible.
- pcsrc_o, flush_d_o and flush_e_o are 0 in IDLE. pc_target_o holds its last value.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-REDIRECT: outputs drop to 0 immediately (async), and the redirect is lost.
- stall_e=1 in IDLE: no evaluation and no counting. The same instruction is evaluated once, when the stall releases.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_BEQ..F3_BGEU
  - FSM state typedef br_state_t {BR_IDLE, BR_REDIRECT}
- Sub-module branch_cond: purely combinational. Inputs are funct3 and Z/N/C/V; outputs are taken and illegal. It is reused by the verification model.
- Counters are inline; no separate module.

Test Plan:
- BEQ with Z=1, target 0x0000_0040, no stall: next cycle pcsrc_o=1, flush_d_o=flush_e_o=1, pc_target_o=0x40; the cycle after, all three are 0. br_count=1, taken_count=1.
- BLTU with C=1 (A>=B): no redirect, br_count=1, taken_count=0. BLT with N=0, V=1: redirect taken.
- Taken branch, then valid_e=1, branch_e=1, Z=1 held during REDIRECT: exactly one redirect, br_count=1.
- stall_e=1 for 3 cycles with BNE Z=0 present, then released: one redirect after release, br_count=1.
- funct3=010, branch_e=1: illegal_br_o pulses 1 cycle, no redirect, br_count=1.
- CNT_W=4, 20 taken jumps: taken_count=15. Async rst=0 during REDIRECT: pcsrc_o=0 before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the EX-stage branch resolution logic.
package riscv_pkg;

  // B-type funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Redirect sequencer states
  typedef enum logic [0:0] {
    BR_IDLE,
    BR_REDIRECT
  } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps funct3 plus ALU flags from A-B to a taken decision.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       carry_i,
  input  logic       ovf_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // Decode the condition; carry is the no-borrow flag of A+~B+1, so C=1 means A>=B unsigned
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = ~zero_i;
      F3_BLT:  taken_o = neg_i ^ ovf_i;
      F3_BGE:  taken_o = ~(neg_i ^ ovf_i);
      F3_BLTU: taken_o = ~carry_i;
      F3_BGEU: taken_o = carry_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers the branch/jump decision, sequences a one-cycle
// PC redirect plus IF/ID and ID/EX flush, and keeps saturating branch statistics.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic [2:0]       funct3_e,
  input  logic             zero_e,
  input  logic             neg_e,
  input  logic             carry_e,
  input  logic             ovf_e,
  input  logic [XLEN-1:0]  pc_target_e,
  output logic             pcsrc_o,
  output logic [XLEN-1:0]  pc_target_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  br_state_t        state_q, state_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
  logic             illegal_q, illegal_d;
  logic             cond_taken, cond_illegal;
  logic             accept, take;

  branch_cond u_cond (
    .funct3_i  (funct3_e),
    .zero_i    (zero_e),
    .neg_i     (neg_e),
    .carry_i   (carry_e),
    .ovf_i     (ovf_e),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  // Next-state: evaluate only in IDLE; the REDIRECT cycle holds a wrong-path instruction
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    br_cnt_d  = br_cnt_q;
    tk_cnt_d  = tk_cnt_q;
    illegal_d = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      BR_IDLE: begin
        accept = valid_e & ~stall_e & (branch_e | jump_e);
        // Jump wins over branch when both are flagged
        take   = jump_e | cond_taken;
        if (accept) begin
          illegal_d = ~jump_e & cond_illegal;
          if (br_cnt_q != CntMax) br_cnt_d = br_cnt_q + 1'b1;
          if (take) begin
            state_d  = BR_REDIRECT;
            target_d = pc_target_e;
            if (tk_cnt_q != CntMax) tk_cnt_d = tk_cnt_q + 1'b1;
          end
        end
      end
      BR_REDIRECT: state_d = BR_IDLE;
      default:     state_d = BR_IDLE;
    endcase
  end

  // State, target, statistics and illegal pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BR_IDLE;
      target_q  <= '0;
      br_cnt_q  <= '0;
      tk_cnt_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      br_cnt_q  <= br_cnt_d;
      tk_cnt_q  <= tk_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Redirect and flushes are decoded straight from the state flop
  always_comb begin
    pcsrc_o       = (state_q == BR_REDIRECT);
    flush_d_o     = (state_q == BR_REDIRECT);
    flush_e_o     = (state_q == BR_REDIRECT);
    pc_target_o   = target_q;
    illegal_br_o  = illegal_q;
    br_count_o    = br_cnt_q;
    taken_count_o = tk_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: flags come from real A-B arithmetic, expected
// decisions from direct operand comparison.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  typedef logic [4+XLEN+2*CNT_W-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid_e = 1'b0, stall_e = 1'b0, branch_e = 1'b0, jump_e = 1'b0;
  logic [2:0]       funct3_e = 3'd0;
  logic             zero_e = 1'b0, neg_e = 1'b0, carry_e = 1'b0, ovf_e = 1'b0;
  logic [XLEN-1:0]  pc_target_e = '0;
  logic             pcsrc_o, flush_d_o, flush_e_o, illegal_br_o;
  logic [XLEN-1:0]  pc_target_o;
  logic [CNT_W-1:0] br_count_o, taken_count_o;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_e       (valid_e),
    .stall_e       (stall_e),
    .branch_e      (branch_e),
    .jump_e        (jump_e),
    .funct3_e      (funct3_e),
    .zero_e        (zero_e),
    .neg_e         (neg_e),
    .carry_e       (carry_e),
    .ovf_e         (ovf_e),
    .pc_target_e   (pc_target_e),
    .pcsrc_o       (pcsrc_o),
    .pc_target_o   (pc_target_o),
    .flush_d_o     (flush_d_o),
    .flush_e_o     (flush_e_o),
    .illegal_br_o  (illegal_br_o),
    .br_count_o    (br_count_o),
    .taken_count_o (taken_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t e;

  // Reference model state
  logic             m_red;
  logic [XLEN-1:0]  m_tgt;
  logic [CNT_W-1:0] m_br, m_tc;

  function automatic vec_t observed();
    return {pcsrc_o, flush_d_o, flush_e_o, illegal_br_o, pc_target_o, br_count_o, taken_count_o};
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_red = 1'b0; m_tgt = '0; m_br = '0; m_tc = '0;
    sb.delete();
  endtask

  // Drive one EX cycle (flags computed from A-B), push the expected post-edge outputs
  task automatic drive(input logic v, s, br, j, input logic [2:0] f3,
                       input logic [31:0] a, b, tgt);
    logic [32:0] sum;
    logic red_n, ill_n, tk;
    sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
    valid_e = v; stall_e = s; branch_e = br; jump_e = j; funct3_e = f3;
    pc_target_e = tgt;
    zero_e  = (sum[31:0] == 32'd0);
    neg_e   = sum[31];
    carry_e = sum[32];
    ovf_e   = (a[31] != b[31]) && (sum[31] != a[31]);
    red_n = 1'b0; ill_n = 1'b0;
    if (!m_red && v && !s && (br || j)) begin
      if (m_br != '1) m_br = m_br + 1'b1;
      if (j) tk = 1'b1;
      else begin
        tk    = ref_taken(f3, a, b);
        ill_n = (f3 == 3'd2) || (f3 == 3'd3);
      end
      if (tk) begin
        red_n = 1'b1;
        m_tgt = tgt;
        if (m_tc != '1) m_tc = m_tc + 1'b1;
      end
    end
    m_red = red_n;
    sb.push_back({red_n, red_n, red_n, ill_n, m_tgt, m_br, m_tc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (observed() !== '0) begin
      n_bad++;
      $display("FAIL reset got %h want %h", observed(), vec_t'(0));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_beq_taken();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd7, 32'd7, 32'h0000_0040);
    idle();
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      // Only the last pop aligns with current outputs; earlier ones were already stale
      if (sb.size() == 0) begin
        n_cmp++;
        if (observed() !== e) begin
          n_bad++;
          $display("FAIL beq_final got %h want %h", observed(), e);
        end
      end
    end
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 32'h0000_0040);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL beq_taken cyc%0d got %h want %h", i, observed(), e);
      end
      idle();
    end
    void'(sb.pop_front());
  endtask

  task automatic test_conditions();
    logic [31:0] ops[8][2];
    ops[0] = '{32'd5, 32'd3};          // BLTU not taken, C=1
    ops[1] = '{32'h8000_0000, 32'd1};  // BLT via N=0,V=1
    ops[2] = '{32'd3, 32'd3};
    ops[3] = '{32'hFFFF_FFFF, 32'd1};
    ops[4] = '{32'd1, 32'hFFFF_FFFF};
    ops[5] = '{32'h7FFF_FFFF, 32'h8000_0000};
    ops[6] = '{$urandom, $urandom};
    ops[7] = '{32'd0, 32'd1};
    do_reset();
    for (int f = 0; f < 8; f++) begin
      if (f == 2 || f == 3) continue;
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'(f), ops[k][0], ops[k][1], 32'h100 + 32'(f * 16 + k));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e) begin
          n_bad++;
          $display("FAIL cond f3=%0d op%0d got %h want %h", f, k, observed(), e);
        end
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e) begin
          n_bad++;
          $display("FAIL cond_after f3=%0d op%0d got %h want %h", f, k, observed(), e);
        end
        if (m_br >= 4'd12) do_reset();
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Taken branch held through the REDIRECT cycle must redirect once
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd4, 32'd4, 32'h0000_0200);
      e = sb.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL b2b cyc%0d got %h want %h", i, observed(), e);
      end
    end
    idle();
    e = sb.pop_front();
    n_cmp++;
    if (observed() !== e) begin
      n_bad++;
      $display("FAIL b2b_end got %h want %h", observed(), e);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'd1, 32'd2, 32'h0000_0300);
      else if (i == 3) drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'd1, 32'd2, 32'h0000_0300);
      else idle();
      e = sb.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL stall cyc%0d got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 32'd0, 32'h0000_0400);
      else if (i == 2) drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'd1, 32'd0, 32'h0000_0404);
      else idle();
      e = sb.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL illegal cyc%0d got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    // Jump+branch with a not-taken condition: jump still wins
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'h1000 + 32'(i));
      e = sb.pop_front();
      if (i % 8 == 0 || i >= 38) begin
        n_cmp++;
        if (observed() !== e) begin
          n_bad++;
          $display("FAIL saturate cyc%0d got %h want %h", i, observed(), e);
        end
      end
    end
    n_cmp++;
    if (taken_count_o !== 4'd15) begin
      n_bad++;
      $display("FAIL saturate_taken got %0d want 15", taken_count_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h0000_0500);
    e = sb.pop_front();
    n_cmp++;
    if (observed() !== e) begin
      n_bad++;
      $display("FAIL async_pre got %h want %h", observed(), e);
    end
    valid_e = 1'b0; jump_e = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== '0) begin
      n_bad++;
      $display("FAIL async_rst got %h want %h", observed(), vec_t'(0));
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    e = sb.pop_front();
    n_cmp++;
    if (observed() !== e) begin
      n_bad++;
      $display("FAIL async_after got %h want %h", observed(), e);
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_conditions();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
